// File: rtl/bitmap_pkg.sv
// Shared types and helpers for the bitmap video RAM access controller.
package bitmap_pkg;

    localparam int AW_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE,
        VRD,
        VDONE,
        CRD,
        CMOD,
        CWR,
        CDONE,
        INC
    } bac_state_t;

    // Replace one nibble of a RAM byte: sel=1 -> high nibble, sel=0 -> low nibble.
    function automatic logic [7:0] nib_merge(
        input logic [7:0] rd_byte,
        input logic [3:0] nib,
        input logic       sel
    );
        return sel ? {nib, rd_byte[3:0]} : {rd_byte[7:4], nib};
    endfunction

endpackage

// File: rtl/bitmap_arb_fair.sv
// CPU/video grant decision for the bitmap RAM; video has priority.
// ACCESS_FAIRNESS_EN adds a starvation counter that forces a CPU grant.
module bitmap_arb_fair
`ifdef ACCESS_FAIRNESS_EN
#(
    parameter int FAIR_LIMIT = 8
)
`endif
(
`ifdef ACCESS_FAIRNESS_EN
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_owner,
`endif
    input  logic idle,
    input  logic cpu_req,
    input  logic vid_req,
    output logic grant_vid,
    output logic grant_cpu
);

    logic force_cpu;

`ifdef ACCESS_FAIRNESS_EN
    localparam int            CW    = $clog2(FAIR_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(FAIR_LIMIT);

    logic [CW-1:0] wait_cnt;

    // Cycles spent by the CPU's own access are not waiting time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (grant_cpu) begin
            wait_cnt <= '0;
        end else if (cpu_req && !cpu_owner && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_cpu = (wait_cnt >= LIMIT);
`else
    assign force_cpu = 1'b0;
`endif

    assign grant_vid = idle && vid_req && !(cpu_req && force_cpu);
    assign grant_cpu = idle && cpu_req && (!vid_req || force_cpu);

endmodule

// File: rtl/bitmap_access_ctrl.sv
// Sequencer for the shared bitmap video RAM: video scanout reads, CPU byte
// accesses and bitmap nibble read-modify-write with X/Y increment strobes.
// Optional macro ACCESS_FAIRNESS_EN bounds CPU starvation under video load.
module bitmap_access_ctrl
    import bitmap_pkg::*;
#(
    parameter int AW         = AW_DEFAULT,
    parameter int FAIR_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce2H,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          BITMDn,
    input  logic [7:0]    cpu_wd,
    input  logic [AW-1:0] BA,
    input  logic [AW-1:0] DRBA,
    input  logic          PIXA,
    input  logic          ax_en,
    input  logic          ay_en,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wd,
    input  logic [7:0]    ram_rd,
    output logic          cpu_ack,
    output logic          vid_ack,
    output logic [7:0]    cpu_rd,
    output logic [7:0]    vid_rd,
    output logic          AXn,
    output logic          AYn,
    output logic          busy
);

    if (FAIR_LIMIT < 1) begin : g_bad_fair_limit
        $error("FAIR_LIMIT must be at least 1");
    end

    bac_state_t state;
    bac_state_t next_state;

    logic       idle;
    logic       cpu_owner;
    logic       grant_vid;
    logic       grant_cpu;

    // Request attributes frozen at grant time.
    logic       pixa_q;
    logic       we_q;
    logic       bitm_q;
    logic [7:0] wd_q;
    logic [7:0] rd_q;

    assign idle      = (state == IDLE);
    assign cpu_owner = state inside {CRD, CMOD, CWR, CDONE, INC};

    bitmap_arb_fair
`ifdef ACCESS_FAIRNESS_EN
    #(
        .FAIR_LIMIT (FAIR_LIMIT)
    )
`endif
    u_arb (
`ifdef ACCESS_FAIRNESS_EN
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_owner (cpu_owner),
`endif
        .idle      (idle),
        .cpu_req   (cpu_req),
        .vid_req   (vid_req),
        .grant_vid (grant_vid),
        .grant_cpu (grant_cpu)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (grant_vid) begin
                    next_state = VRD;
                end else if (grant_cpu) begin
                    next_state = (BITMDn && cpu_we) ? CWR : CRD;
                end
            end
            VRD:   next_state = VDONE;
            VDONE: next_state = IDLE;
            CRD:   next_state = (bitm_q && we_q) ? CMOD : CDONE;
            CMOD:  next_state = CWR;
            CWR:   next_state = CDONE;
            CDONE: next_state = (bitm_q && (ax_en || ay_en)) ? INC : IDLE;
            INC:   next_state = ce2H ? IDLE : INC;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixa_q <= 1'b0;
            we_q   <= 1'b0;
            bitm_q <= 1'b0;
            wd_q   <= '0;
            rd_q   <= '0;
        end else begin
            if (grant_vid) begin
                we_q   <= 1'b0;
                bitm_q <= 1'b0;
            end else if (grant_cpu) begin
                pixa_q <= PIXA;
                we_q   <= cpu_we;
                bitm_q <= !BITMDn;
                wd_q   <= cpu_wd;
            end
            if (state == CRD) begin
                rd_q <= ram_rd;
            end
        end
    end

    // Outputs are decoded from next_state so each registered strobe is
    // visible during the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_wd   <= '0;
            cpu_rd   <= '0;
            vid_rd   <= '0;
            cpu_ack  <= 1'b0;
            vid_ack  <= 1'b0;
            AXn      <= 1'b1;
            AYn      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            ram_we  <= (next_state == CWR);
            cpu_ack <= (next_state == CDONE);
            vid_ack <= (next_state == VDONE);
            busy    <= (next_state != IDLE);
            AXn     <= !((state == INC) && ce2H && ax_en);
            AYn     <= !((state == INC) && ce2H && ay_en);

            if (grant_vid) begin
                ram_addr <= vid_addr;
            end else if (grant_cpu) begin
                ram_addr <= BITMDn ? BA : DRBA;
            end

            if (grant_cpu && BITMDn && cpu_we) begin
                ram_wd <= cpu_wd;
            end else if (state == CMOD) begin
                ram_wd <= nib_merge(rd_q, wd_q[3:0], pixa_q);
            end

            if (state == VRD) begin
                vid_rd <= ram_rd;
            end

            if ((state == CRD) && !we_q) begin
                cpu_rd <= bitm_q ? {4'h0, (pixa_q ? ram_rd[7:4] : ram_rd[3:0])}
                                 : ram_rd;
            end
        end
    end

endmodule
